// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. A FIFO absorbs single-cycle store strobes and a serializer sends each byte LSB first.
// Optional macro UART_TX_PARITY_EN adds an even parity bit, giving 8E1 instead of 8N1.
// Ports:
//   clk, rst (async, active-high)
//   uart_we, wr_data[7:0]      byte enqueue strobe and data
//   ovf_clr                    clears the sticky overflow flag
//   full, empty, level         FIFO status, taken from the registered count
//   busy                       serializer is not idle
//   overflow                   sticky flag: a write was dropped
//   uart_tx                    registered serial line, idle high
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_we,
    input  logic [7:0]               wr_data,
    input  logic                     ovf_clr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow,
    output logic                     uart_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          bit_end, pop, push;

    assign bit_end = cnt == CMAX;
    // The head byte is popped when idle, or at the end of a stop bit so that frames run back to back.
    assign pop     = !empty && (state == IDLE || (state == STOP && bit_end));
    // When the FIFO is full, a write is still accepted if a pop frees a slot on the same edge.
    assign push    = uart_we && (!full || pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign level   = count;
    assign busy    = state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wptr] <= wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (uart_we && !push) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rptr];
`ifdef UART_TX_PARITY_EN
                        par     <= ^mem[rptr];
`endif
                        uart_tx <= 1'b0;
                        cnt     <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        idx     <= '0;
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end else cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= par;
                            state   <= PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= STOP;
`endif
                        end else uart_tx <= shift[1];
                    end else cnt <= cnt + 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end else cnt <= cnt + 1'b1;
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shift   <= mem[rptr];
`ifdef UART_TX_PARITY_EN
                            par     <= ^mem[rptr];
`endif
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            uart_tx <= 1'b1;
                            state   <= IDLE;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with DEPTH=4 and CLKS_PER_BIT=4.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11 * CPB;
`else
    localparam int FL = 10 * CPB;
`endif
    logic       clk = 1'b0, rst = 1'b1, uart_we = 1'b0, ovf_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, overflow, uart_tx;
    logic [2:0] level;
    int         n_cmp = 0, n_err = 0;

    uart_tx_fifo #(.DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .uart_we(uart_we), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .full(full), .empty(empty), .level(level), .busy(busy), .overflow(overflow), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line value k cycles after the start bit begins.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int t;
        t = k / CPB;
        if (t == 0) return 1'b0;
        if (t <= 8) return b[t-1];
`ifdef UART_TX_PARITY_EN
        if (t == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset;
        int bad;
        bad = 0;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", full); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL reset_idle_line: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_single;
        uart_we = 1'b1;
        wr_data = 8'h55;
        tick();
        uart_we = 1'b0;
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level_after_write: got %0d expected 1", level); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL single_tx_before_pop: got %b expected 1", uart_tx); end
        for (int k = 0; k < FL; k++) begin
            tick();
            n_cmp++; if (uart_tx !== exp_bit(8'h55, k)) begin n_err++; $display("FAIL single_bit k=%0d: got %b expected %b", k, uart_tx, exp_bit(8'h55, k)); end
            if (k == 0) begin
                n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_level_on_pop: got %0d expected 0", level); end
            end
            if (k == FL - 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_last: got %b expected 1", busy); end
            end
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL single_tx_idle: got %b expected 1", uart_tx); end
    endtask

    task automatic test_burst;
        logic [7:0] bytes [3];
        int peak;
        bytes = '{8'h41, 8'h42, 8'h43};
        uart_we = 1'b1;
        wr_data = 8'h41;
        tick();
        peak = int'(level);
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL burst_level0: got %0d expected 1", level); end
        for (int k = 0; k < 3 * FL; k++) begin
            uart_we = (k < 2);
            wr_data = (k == 0) ? 8'h42 : 8'h43;
            tick();
            if (int'(level) > peak) peak = int'(level);
            n_cmp++; if (uart_tx !== exp_bit(bytes[k / FL], k % FL)) begin n_err++; $display("FAIL burst_bit k=%0d: got %b expected %b", k, uart_tx, exp_bit(bytes[k / FL], k % FL)); end
            if (k == 1) begin
                n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL burst_level_peak_at_k1: got %0d expected 2", level); end
            end
        end
        uart_we = 1'b0;
        n_cmp++; if (peak != 2) begin n_err++; $display("FAIL burst_peak: got %0d expected 2", peak); end
        tick();
        n_cmp++; if (busy !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL burst_done: got busy=%b empty=%b expected busy=0 empty=1", busy, empty); end
    endtask

    task automatic test_overflow;
        logic [7:0] bytes [6];
        bytes = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        uart_we = 1'b1;
        wr_data = 8'hF0;
        tick();
        for (int k = 0; k < 6 * FL; k++) begin
            uart_we = (k >= 1 && k <= 5) || k == FL;
            wr_data = (k == FL) ? 8'h06 : 8'(k);
            ovf_clr = (k == 6);
            tick();
            n_cmp++; if (uart_tx !== exp_bit(bytes[k / FL], k % FL)) begin n_err++; $display("FAIL ovf_bit k=%0d: got %b expected %b", k, uart_tx, exp_bit(bytes[k / FL], k % FL)); end
            if (k == 3) begin
                n_cmp++; if (full !== 1'b0 || level !== 3'd3) begin n_err++; $display("FAIL ovf_level3: got full=%b level=%0d expected full=0 level=3", full, level); end
            end
            if (k == 4) begin
                n_cmp++; if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_full: got full=%b level=%0d ovf=%b expected 1/4/0", full, level, overflow); end
            end
            if (k == 5) begin
                n_cmp++; if (overflow !== 1'b1 || level !== 3'd4) begin n_err++; $display("FAIL ovf_drop: got ovf=%b level=%0d expected 1/4", overflow, level); end
            end
            if (k == 6) begin
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
            end
            if (k == FL) begin
                n_cmp++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_full_pop_write: got level=%0d full=%b ovf=%b expected 4/1/0", level, full, overflow); end
            end
        end
        uart_we = 1'b0;
        ovf_clr = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL ovf_done: got busy=%b empty=%b expected 0/1", busy, empty); end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        uart_we = 1'b1;
        wr_data = 8'hA5;
        tick();
        for (int k = 0; k < 18; k++) begin
            uart_we = (k == 1 || k == 2);
            wr_data = (k == 1) ? 8'h11 : 8'h22;
            tick();
            n_cmp++; if (uart_tx !== exp_bit(8'hA5, k)) begin n_err++; $display("FAIL mid_bit k=%0d: got %b expected %b", k, uart_tx, exp_bit(8'hA5, k)); end
        end
        uart_we = 1'b0;
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL mid_queued: got %0d expected 2", level); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL mid_tx: got %b expected 1", uart_tx); end
        n_cmp++; if (level !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL mid_flush: got level=%0d empty=%b expected 0/1", level, empty); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mid_residual: got %0d bad cycles expected 0", bad); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] bytes [2];
        bytes = '{8'h07, 8'h03};
        for (int j = 0; j < 2; j++) begin
            uart_we = 1'b1;
            wr_data = bytes[j];
            tick();
            uart_we = 1'b0;
            for (int k = 0; k < FL; k++) begin
                tick();
                n_cmp++; if (uart_tx !== exp_bit(bytes[j], k)) begin n_err++; $display("FAIL parity_bit byte=%0h k=%0d: got %b expected %b", bytes[j], k, uart_tx, exp_bit(bytes[j], k)); end
            end
            tick();
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL parity_len byte=%0h: got busy=%b expected 0", bytes[j], busy); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
